// File: rtl/servo_leg_one_pkg.sv
// servo_leg_one_pkg: shared angle/LUT formats, angle constants, ROM and PWM defaults, asin table entry
package servo_leg_one_pkg;
  localparam int ANGLE_W = 13;
  localparam int LUT_W = 16;
  localparam int ANGLE_FRAC = 10;
  localparam int PW_W = 22;
  localparam int ROM_ADDR_W = 10;
  localparam int ROM_DEPTH = 2 ** ROM_ADDR_W;
  localparam int PWM_PERIOD = 1_000_000;
  localparam int PWM_CENTER = 75_000;
  localparam int PWM_PER_LSB = 98;
  localparam real PI = 3.141592653589793;
  typedef logic signed [ANGLE_W-1:0] angle_t;
  localparam angle_t ZERO = 13'sd0;
  localparam angle_t THIRTY = 13'sd170;
  localparam angle_t NTHIRTY = -13'sd170;
  localparam angle_t NINETY = 13'sd512;
  function automatic int asin_entry(int i, int aw);
    real y;
    y = $asin(real'(i) * 2.0 / real'(2 ** aw) - 1.0) * 1024.0 / PI;
    return y < 0.0 ? -$rtoi(0.5 - y) : $rtoi(y + 0.5);
  endfunction
endpackage

// File: rtl/servo_leg_one_if.sv
// servo_leg_one_if: pose-stage to servo-leg link carrying the asin argument, atan term and resulting alpha
interface servo_leg_one_if;
  import servo_leg_one_pkg::*;
  logic validIn;
  logic signed [LUT_W-1:0] LUTin;
  angle_t atan;
  angle_t alpha;
  logic alphaValid;
  logic fault;
  modport master(output validIn, LUTin, atan, input alpha, alphaValid, fault);
  modport slave(input validIn, LUTin, atan, output alpha, alphaValid, fault);
endinterface

// File: rtl/servo_leg_one_asin_rom.sv
// servo_leg_one_asin_rom: synchronous asin table, entry i = round(asin(2i/2^ADDR_W - 1) * 1024/pi)
module servo_leg_one_asin_rom
  import servo_leg_one_pkg::*;
#(
  parameter int ADDR_W = ROM_ADDR_W
) (
  input logic clock,
  input logic [ADDR_W-1:0] addr,
  output angle_t data
);
  angle_t rom [2 ** ADDR_W];
  for (genvar i = 0; i < 2 ** ADDR_W; i++) begin : g_rom
    assign rom[i] = ANGLE_W'(asin_entry(i, ADDR_W));
  end
  always_ff @(posedge clock) data <= rom[addr];
endmodule

// File: rtl/servo_leg_one.sv
// servo_leg_one: forms alpha = asin(LUTin) - atan, range-checks it and drives a glitch-free servo PWM pin
module servo_leg_one
  import servo_leg_one_pkg::*;
#(
  parameter int ADDR_W = ROM_ADDR_W,
  parameter int PERIOD_CYC = PWM_PERIOD,
  parameter int PW_CENTER = PWM_CENTER,
  parameter int PW_PER_LSB = PWM_PER_LSB,
  parameter int ALPHA_MIN = -512,
  parameter int ALPHA_MAX = 511
) (
  input logic clock,
  input logic reset,
  servo_leg_one_if.slave bus,
  output logic pwm
);
  localparam int CNT_W = $clog2(PERIOD_CYC);
  localparam int D_W = ANGLE_W + 1;
  localparam logic signed [LUT_W-1:0] LUT_ONE = 16'sd16384;
  logic signed [LUT_W-1:0] lut_c;
  logic [ADDR_W:0] idx;
  logic [ADDR_W-1:0] addr1_d, addr1_q;
  logic v1_q, v2_q, r1_d, r1_q, r2_q, ok;
  angle_t atan1_q, atan2_q, asin2, alpha_d, alpha_q;
  logic signed [D_W-1:0] d;
  logic [PW_W-1:0] pw, shadow_d, shadow_q, active_d, active_q;
  logic [CNT_W-1:0] counter_d, counter_q;
  logic wrap, fault_d, fault_q, alpha_valid_q, pwm_d, pwm_q;
  always_comb begin
    lut_c = bus.LUTin < -LUT_ONE ? -LUT_ONE : (bus.LUTin > LUT_ONE ? LUT_ONE : bus.LUTin);
    r1_d = bus.LUTin != lut_c;
    idx = (ADDR_W + 1)'(((LUT_W + 1)'(lut_c) + (LUT_W + 1)'(LUT_ONE)) >> (LUT_W - 1 - ADDR_W));
    addr1_d = idx[ADDR_W] ? '1 : idx[ADDR_W-1:0];
    d = D_W'(asin2) - D_W'(atan2_q);
    ok = v2_q && !r2_q && 32'(d) >= ALPHA_MIN && 32'(d) <= ALPHA_MAX;
    fault_d = fault_q || (v2_q && !ok);
    alpha_d = ok ? d[ANGLE_W-1:0] : alpha_q;
    pw = PW_W'(PW_CENTER) + {{(PW_W - D_W){d[D_W-1]}}, d} * PW_W'(PW_PER_LSB);
    shadow_d = ok ? pw : shadow_q;
    wrap = counter_q == CNT_W'(PERIOD_CYC - 1);
    counter_d = wrap ? '0 : counter_q + 1'b1;
    active_d = wrap ? shadow_d : active_q;
    pwm_d = PW_W'(counter_d) < active_d;
  end
  servo_leg_one_asin_rom #(.ADDR_W(ADDR_W)) u_rom (.clock(clock), .addr(addr1_q), .data(asin2));
  always_ff @(posedge clock) begin
    atan1_q <= bus.atan;
    r1_q <= r1_d;
    addr1_q <= addr1_d;
    atan2_q <= atan1_q;
    r2_q <= r1_q;
  end
  always_ff @(posedge clock) begin
    if (!reset) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      alpha_valid_q <= 1'b0;
      alpha_q <= '0;
      fault_q <= 1'b0;
      shadow_q <= PW_W'(PW_CENTER);
      active_q <= PW_W'(PW_CENTER);
      counter_q <= '0;
      pwm_q <= 1'b0;
    end else begin
      v1_q <= bus.validIn;
      v2_q <= v1_q;
      alpha_valid_q <= v2_q;
      alpha_q <= alpha_d;
      fault_q <= fault_d;
      shadow_q <= shadow_d;
      active_q <= active_d;
      counter_q <= counter_d;
      pwm_q <= pwm_d;
    end
  end
  assign bus.alpha = alpha_q;
  assign bus.alphaValid = alpha_valid_q;
  assign bus.fault = fault_q;
  assign pwm = pwm_q;
endmodule

// File: tb/tb_servo_leg_one.sv
// tb_servo_leg_one: directed checks of alpha pipeline, fault handling and PWM frame updates
module tb_servo_leg_one;
  import servo_leg_one_pkg::*;
  localparam int PER = 3000;
  localparam int CEN = 1100;
  localparam int LSB = 2;
  logic clock = 1'b0;
  logic reset = 1'b0;
  logic pwm;
  int n_cmp = 0;
  int n_bad = 0;
  servo_leg_one_if bus();
  servo_leg_one #(.PERIOD_CYC(PER), .PW_CENTER(CEN), .PW_PER_LSB(LSB)) dut (
    .clock(clock), .reset(reset), .bus(bus), .pwm(pwm)
  );
  always #5 clock = ~clock;
  task automatic run_sample(input logic signed [15:0] lut, input angle_t at, output logic e, output logic v,
                            output angle_t a, output logic f);
    bus.validIn = 1'b1;
    bus.LUTin = lut;
    bus.atan = at;
    @(negedge clock);
    bus.validIn = 1'b0;
    @(negedge clock);
    e = bus.alphaValid;
    @(negedge clock);
    v = bus.alphaValid;
    a = bus.alpha;
    f = bus.fault;
  endtask
  task automatic wait_rise();
    int t = 0;
    while (pwm === 1'b1 && t < 3 * PER) begin @(negedge clock); t++; end
    while (pwm !== 1'b1 && t < 3 * PER) begin @(negedge clock); t++; end
  endtask
  task automatic measure(output int w);
    wait_rise();
    w = 0;
    while (pwm === 1'b1 && w < PER) begin w++; @(negedge clock); end
  endtask
  task automatic test_reset();
    int hi = 0;
    bus.validIn = 1'b0;
    bus.LUTin = '0;
    bus.atan = '0;
    repeat (5) @(negedge clock);
    n_cmp++;
    if ({pwm, bus.alpha, bus.alphaValid, bus.fault} !== '0) begin
      n_bad++;
      $display("FAIL reset_state: pwm %b alpha %0d valid %b fault %b, expected all 0", pwm, bus.alpha, bus.alphaValid, bus.fault);
    end
    reset = 1'b1;
    repeat (PER) begin @(negedge clock); hi += int'(pwm); end
    n_cmp++;
    if (hi !== CEN) begin n_bad++; $display("FAIL reset_frame_high: got %0d expected %0d", hi, CEN); end
    n_cmp++;
    if ({bus.alpha, bus.fault} !== '0) begin n_bad++; $display("FAIL idle_outputs: alpha %0d fault %b expected 0 0", bus.alpha, bus.fault); end
  endtask
  task automatic test_basic();
    logic e, v, f;
    angle_t a;
    int w;
    run_sample(16'sd0, NTHIRTY, e, v, a, f);
    n_cmp++;
    if ({e, v, a, f} !== {1'b0, 1'b1, 13'(170), 1'b0}) begin
      n_bad++;
      $display("FAIL basic_alpha: valid %b/%b alpha %0d fault %b expected 0/1 170 0", e, v, a, f);
    end
    measure(w);
    n_cmp++;
    if (w !== CEN + 170 * LSB) begin n_bad++; $display("FAIL basic_width: got %0d expected %0d", w, CEN + 170 * LSB); end
  endtask
  task automatic test_back_to_back();
    for (int k = 1; k <= 3; k++) begin
      bus.validIn = 1'b1;
      bus.LUTin = '0;
      bus.atan = 13'(-10 * k);
      @(negedge clock);
    end
    bus.validIn = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      n_cmp++;
      if ({bus.alphaValid, bus.alpha} !== {1'b1, 13'(10 * k)}) begin
        n_bad++;
        $display("FAIL b2b_%0d: valid %b alpha %0d expected 1 %0d", k, bus.alphaValid, bus.alpha, 10 * k);
      end
      @(negedge clock);
    end
    n_cmp++;
    if (bus.alphaValid !== 1'b0) begin n_bad++; $display("FAIL b2b_end: valid %b expected 0", bus.alphaValid); end
  endtask
  task automatic test_full_scale();
    logic e, v, f;
    angle_t a;
    real y = $asin(1023.0 * 2.0 / 1024.0 - 1.0) * 1024.0 / PI;
    int rv = $rtoi(y + 0.5);
    int ea = rv > 511 ? 30 : rv;
    logic ef = rv > 511;
    run_sample(16'sd16384, ZERO, e, v, a, f);
    n_cmp++;
    if ({e, v, a, f} !== {1'b0, 1'b1, 13'(ea), ef}) begin
      n_bad++;
      $display("FAIL full_scale: valid %b/%b alpha %0d fault %b expected 0/1 %0d %b", e, v, a, f, ea, ef);
    end
  endtask
  task automatic test_min_alpha();
    logic e, v, f;
    angle_t a;
    int w;
    run_sample(-16'sd16384, ZERO, e, v, a, f);
    n_cmp++;
    if ({e, v, a, f} !== {1'b0, 1'b1, 13'(-512), 1'b0}) begin
      n_bad++;
      $display("FAIL min_alpha: valid %b/%b alpha %0d fault %b expected 0/1 -512 0", e, v, a, f);
    end
    measure(w);
    n_cmp++;
    if (w !== CEN - 512 * LSB) begin n_bad++; $display("FAIL min_width: got %0d expected %0d", w, CEN - 512 * LSB); end
  endtask
  task automatic test_unreachable();
    logic e, v, f;
    angle_t a;
    int w;
    run_sample(16'sd20000, ZERO, e, v, a, f);
    n_cmp++;
    if ({e, v, a, f} !== {1'b0, 1'b1, 13'(-512), 1'b1}) begin
      n_bad++;
      $display("FAIL unreachable: valid %b/%b alpha %0d fault %b expected 0/1 -512 1", e, v, a, f);
    end
    measure(w);
    n_cmp++;
    if (w !== CEN - 512 * LSB) begin n_bad++; $display("FAIL unreachable_width: got %0d expected %0d", w, CEN - 512 * LSB); end
    run_sample(16'sd0, ZERO, e, v, a, f);
    n_cmp++;
    if ({e, v, a, f} !== {1'b0, 1'b1, 13'(0), 1'b1}) begin
      n_bad++;
      $display("FAIL sticky_fault: valid %b/%b alpha %0d fault %b expected 0/1 0 1", e, v, a, f);
    end
    measure(w);
    n_cmp++;
    if (w !== CEN) begin n_bad++; $display("FAIL recover_width: got %0d expected %0d", w, CEN); end
  endtask
  task automatic test_mid_frame();
    int cnt = 0;
    int w;
    wait_rise();
    while (pwm === 1'b1 && cnt < PER) begin
      bus.validIn = cnt == 5 || cnt == 15;
      bus.LUTin = '0;
      bus.atan = cnt == 5 ? -13'sd100 : 13'sd100;
      @(negedge clock);
      cnt++;
    end
    bus.validIn = 1'b0;
    n_cmp++;
    if (cnt !== CEN) begin n_bad++; $display("FAIL mid_frame_current: got %0d expected %0d", cnt, CEN); end
    n_cmp++;
    if (bus.alpha !== -13'sd100) begin n_bad++; $display("FAIL mid_frame_alpha: got %0d expected -100", bus.alpha); end
    measure(w);
    n_cmp++;
    if (w !== CEN - 100 * LSB) begin n_bad++; $display("FAIL mid_frame_next: got %0d expected %0d", w, CEN - 100 * LSB); end
  endtask
  task automatic test_wrap_update();
    int w;
    wait_rise();
    repeat (PER - 3) @(negedge clock);
    bus.validIn = 1'b1;
    bus.LUTin = '0;
    bus.atan = 13'sd200;
    @(negedge clock);
    bus.validIn = 1'b0;
    measure(w);
    n_cmp++;
    if (w !== CEN - 200 * LSB) begin n_bad++; $display("FAIL wrap_update: got %0d expected %0d", w, CEN - 200 * LSB); end
    n_cmp++;
    if (bus.alpha !== -13'sd200) begin n_bad++; $display("FAIL wrap_alpha: got %0d expected -200", bus.alpha); end
  endtask
  task automatic test_reset_mid_pipe();
    logic seen = 1'b0;
    int hi = 0;
    bus.validIn = 1'b1;
    bus.LUTin = '0;
    bus.atan = -13'sd50;
    @(negedge clock);
    bus.validIn = 1'b0;
    reset = 1'b0;
    repeat (3) begin @(negedge clock); seen |= bus.alphaValid; end
    n_cmp++;
    if ({pwm, bus.alpha, bus.fault} !== '0) begin
      n_bad++;
      $display("FAIL mid_reset_state: pwm %b alpha %0d fault %b expected 0 0 0", pwm, bus.alpha, bus.fault);
    end
    reset = 1'b1;
    repeat (PER) begin @(negedge clock); hi += int'(pwm); seen |= bus.alphaValid; end
    n_cmp++;
    if (seen !== 1'b0) begin n_bad++; $display("FAIL mid_reset_valid: alphaValid seen %b expected 0", seen); end
    n_cmp++;
    if (hi !== CEN) begin n_bad++; $display("FAIL mid_reset_width: got %0d expected %0d", hi, CEN); end
  endtask
  task automatic test_alpha_range();
    logic e, v, f;
    angle_t a;
    int w;
    run_sample(-16'sd16384, 13'sd1, e, v, a, f);
    n_cmp++;
    if ({e, v, a, f} !== {1'b0, 1'b1, 13'(0), 1'b1}) begin
      n_bad++;
      $display("FAIL alpha_below_min: valid %b/%b alpha %0d fault %b expected 0/1 0 1", e, v, a, f);
    end
    measure(w);
    n_cmp++;
    if (w !== CEN) begin n_bad++; $display("FAIL alpha_below_min_width: got %0d expected %0d", w, CEN); end
  endtask
  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_full_scale();
    test_min_alpha();
    test_unreachable();
    test_mid_frame();
    test_wrap_update();
    test_reset_mid_pipe();
    test_alpha_range();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
